// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: oversampled start/data/stop sampling into a one-entry
// hold register with ready/read handshake, framing/overrun flags and a frame count.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       bclk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rd,
  output logic [7:0] d_out,
  output logic       rx_ready,
  output logic       framing_err,
  output logic       overrun_err,
  output logic [7:0] rx_count
);

  localparam int unsigned CW   = $clog2(OVERSAMPLE);
  localparam int unsigned HALF = OVERSAMPLE / 2;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic          sync1_q, sync2_q;
  logic          rxs;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] samp_cnt_q, samp_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rhr_q, rhr_d;
  logic          ready_q, ready_d;
  logic          ferr_q, ferr_d;
  logic          oerr_q, oerr_d;
  logic [7:0]    count_q, count_d;
  logic          half_hit_c, full_hit_c;

  assign rxs        = sync2_q;
  assign half_hit_c = (samp_cnt_q == CW'(HALF - 1));
  assign full_hit_c = (samp_cnt_q == CW'(OVERSAMPLE - 1));

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rhr_q      <= '0;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      sync1_q    <= rx_in;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rhr_q      <= rhr_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
      oerr_q     <= oerr_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rhr_d      = rhr_q;
    ready_d    = ready_q;
    ferr_d     = ferr_q;
    oerr_d     = oerr_q;
    count_d    = count_q;

    // A read consumes the RHR and clears overrun; a same-cycle load below overrides ready.
    if (rd) begin
      ready_d = 1'b0;
      oerr_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d    = START;
          samp_cnt_d = '0;
        end
      end
      START: begin
        if (half_hit_c) begin
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = rxs ? IDLE : DATA;
        end else begin
          samp_cnt_d = samp_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (full_hit_c) begin
          samp_cnt_d = '0;
          shift_d    = {rxs, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          samp_cnt_d = samp_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (full_hit_c) begin
          samp_cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
            ferr_d  = 1'b0;
            if (!ready_q || rd) begin
              rhr_d   = shift_q;
              ready_d = 1'b1;
              count_d = count_q + 8'd1;
            end else begin
              oerr_d = 1'b1;
            end
          end else begin
            state_d = WAIT_HIGH;
            ferr_d  = 1'b1;
          end
        end else begin
          samp_cnt_d = samp_cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign d_out       = rhr_q;
  assign rx_ready    = ready_q;
  assign framing_err = ferr_q;
  assign overrun_err = oerr_q;
  assign rx_count    = count_q;

endmodule
